uart_pwd_ctrl: RTL and testbench

- Byte-level command controller between the UART receiver/transmitter pair and the board pins.
- Holds a DEPTH-entry secret buffer that a host can set, verify, and read back (only once unlocked).
- Counts failed verifies and enters lockout after MAX_FAIL failures.
- Drives an LED and a stretched active-low target-reset pulse. Parametrised successor of the fixed 16-byte controller; UART cores stay outside the block.

---
 rtl/uart_pwd_pkg.sv | 33 +++
 rtl/pulse_stretch.sv | 31 +++
 rtl/uart_pwd_ctrl.sv | 277 +++++++++++++++++++++++++++
 tb/tb_uart_pwd_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pwd_pkg.sv
// Shared types and byte constants for the UART password controller.
// Imported by the controller top and its reset-pulse stretcher.
package uart_pwd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SET,
      VERIFY,
      DUMP,
      REPLY,
      LOCKED
   } state_t;

   localparam logic [7:0] CMD_TOGGLE = 8'h74;
   localparam logic [7:0] CMD_SET    = 8'h73;
   localparam logic [7:0] CMD_VERIFY = 8'h76;
   localparam logic [7:0] CMD_GET    = 8'h67;
   localparam logic [7:0] CMD_ESC    = 8'h1B;

   localparam logic [7:0] RSP_OK     = 8'h4B;
   localparam logic [7:0] RSP_YES    = 8'h59;
   localparam logic [7:0] RSP_NO     = 8'h4E;
   localparam logic [7:0] RSP_TMO    = 8'h54;
   localparam logic [7:0] RSP_LCK    = 8'h4C;

   // Power-up secret byte i is "A"+i.
   function automatic logic [7:0] init_byte(input int i);
      logic [7:0] b;
      b = 8'h41 + i[7:0];
      return b;
   endfunction

endpackage

// File: rtl/pulse_stretch.sv
// Stretches a one-cycle trigger into an active-low pulse.
// A trigger during an active pulse restarts the full length.
module pulse_stretch
   import uart_pwd_pkg::*;
#(
   parameter int RST_CYCLES = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic trig,
   output logic tgt_rst_n
);

   localparam int CW = $clog2(RST_CYCLES + 1);

   logic [CW-1:0] cnt_q;

   // Reload on trigger, otherwise count down to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (trig) begin
         cnt_q <= CW'(RST_CYCLES);
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign tgt_rst_n = (cnt_q == '0);

endmodule

// File: rtl/uart_pwd_ctrl.sv
// Byte-level command controller: secret set/verify/dump,
// failure lockout, status LED and target reset pulse.
module uart_pwd_ctrl
   import uart_pwd_pkg::*;
#(
   parameter int DEPTH       = 16,
   parameter int DW          = 8,
   parameter int MAX_FAIL    = 3,
   parameter int RST_CYCLES  = 32,
   parameter int TIMEOUT_CYC = 3200000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] rx_data,
   input  logic          rx_valid,
   input  logic          tx_rdy,
   output logic          tx_en,
   output logic [DW-1:0] tx_data,
   output logic          led,
   output logic          tgt_rst_n,
   output logic          locked,
   output logic          unlocked
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int FW = $clog2(MAX_FAIL + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   localparam logic [IW-1:0] IDX_LAST = IW'(DEPTH - 1);
   localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAIL);
   localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYC - 1);

   state_t        state_q, state_n;
   logic [IW-1:0] idx_q, idx_n;
   logic          mis_q, mis_n;
   logic [DW-1:0] rep_q, rep_n;
   logic          rlk_q, rlk_n;
   logic          tog_q, tog_n;
   logic [FW-1:0] fail_q, fail_n;
   logic          lock_q, lock_n;
   logic          unl_q, unl_n;
   logic          busy_q, busy_n;
   logic [TW-1:0] tmr_q, tmr_n;
   logic          txe_q, txe_n;
   logic [DW-1:0] txd_q, txd_n;
   logic          led_q, led_n;

   logic [DW-1:0] secret_q [DEPTH];

   logic          wr_en;
   logic          esc;
   logic          can_tx;
   logic          last;
   logic          hit;
   logic [DW-1:0] cur;
   logic [FW-1:0] fail_inc;

   logic is_tog, is_set, is_ver, is_get, is_esc;

   assign is_tog = (rx_data == DW'(CMD_TOGGLE));
   assign is_set = (rx_data == DW'(CMD_SET));
   assign is_ver = (rx_data == DW'(CMD_VERIFY));
   assign is_get = (rx_data == DW'(CMD_GET));
   assign is_esc = (rx_data == DW'(CMD_ESC));

   assign cur      = secret_q[idx_q];
   assign last     = (idx_q == IDX_LAST);
   assign can_tx   = tx_rdy & ~busy_q;
   assign hit      = mis_q | (rx_data != cur);
   assign fail_inc = (fail_q == FAIL_MAX) ? fail_q
                                         : fail_q + 1'b1;

   // Next-state and next-register logic for the whole controller.
   always_comb begin
      state_n = state_q;
      idx_n   = idx_q;
      mis_n   = mis_q;
      rep_n   = rep_q;
      rlk_n   = rlk_q;
      tog_n   = tog_q;
      fail_n  = fail_q;
      lock_n  = lock_q;
      unl_n   = unl_q;
      tmr_n   = tmr_q;
      txe_n   = 1'b0;
      txd_n   = txd_q;
      wr_en   = 1'b0;
      esc     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (rx_valid) begin
               unique case (1'b1)
                  is_tog: tog_n = ~tog_q;
                  is_set: begin
                     idx_n   = '0;
                     tmr_n   = '0;
                     state_n = SET;
                  end
                  is_ver: begin
                     idx_n   = '0;
                     mis_n   = 1'b0;
                     tmr_n   = '0;
                     state_n = VERIFY;
                  end
                  is_get: begin
                     if (unl_q) begin
                        idx_n   = '0;
                        state_n = DUMP;
                     end else begin
                        rep_n   = DW'(RSP_NO);
                        rlk_n   = 1'b0;
                        state_n = REPLY;
                     end
                  end
                  is_esc: esc = 1'b1;
                  default: begin
                     rep_n   = rx_data;
                     rlk_n   = 1'b0;
                     state_n = REPLY;
                  end
               endcase
            end
         end

         SET: begin
            if (rx_valid) begin
               wr_en = 1'b1;
               idx_n = idx_q + 1'b1;
               tmr_n = '0;
               if (last) begin
                  idx_n   = '0;
                  unl_n   = 1'b0;
                  rep_n   = DW'(RSP_OK);
                  rlk_n   = 1'b0;
                  state_n = REPLY;
               end
            end else if (tmr_q == TMR_LAST) begin
               rep_n   = DW'(RSP_TMO);
               rlk_n   = 1'b0;
               state_n = REPLY;
            end else begin
               tmr_n = tmr_q + 1'b1;
            end
         end

         VERIFY: begin
            if (rx_valid) begin
               mis_n = hit;
               idx_n = idx_q + 1'b1;
               tmr_n = '0;
               if (last) begin
                  idx_n   = '0;
                  state_n = REPLY;
                  if (!hit) begin
                     unl_n  = 1'b1;
                     fail_n = '0;
                     rep_n  = DW'(RSP_YES);
                     rlk_n  = 1'b0;
                  end else begin
                     unl_n  = 1'b0;
                     fail_n = fail_inc;
                     rep_n  = DW'(RSP_NO);
                     rlk_n  = (fail_inc == FAIL_MAX);
                     lock_n = lock_q | (fail_inc == FAIL_MAX);
                  end
               end
            end else if (tmr_q == TMR_LAST) begin
               rep_n   = DW'(RSP_TMO);
               rlk_n   = 1'b0;
               state_n = REPLY;
            end else begin
               tmr_n = tmr_q + 1'b1;
            end
         end

         DUMP: begin
            if (can_tx) begin
               txe_n = 1'b1;
               txd_n = cur;
               idx_n = idx_q + 1'b1;
               if (last) begin
                  idx_n   = '0;
                  state_n = IDLE;
               end
            end
         end

         REPLY: begin
            if (can_tx) begin
               txe_n   = 1'b1;
               txd_n   = rep_q;
               state_n = rlk_q ? LOCKED : IDLE;
            end
         end

         LOCKED: begin
            if (rx_valid) begin
               if (is_esc) begin
                  esc = 1'b1;
               end else begin
                  rep_n   = DW'(RSP_LCK);
                  rlk_n   = 1'b1;
                  state_n = REPLY;
               end
            end
         end

         default: state_n = IDLE;
      endcase

      busy_n = txe_n | (busy_q & tx_rdy);
      led_n  = (state_n == IDLE) ^ tog_n;
   end

   // Controller state and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         mis_q   <= 1'b0;
         rep_q   <= '0;
         rlk_q   <= 1'b0;
         tog_q   <= 1'b0;
         fail_q  <= '0;
         lock_q  <= 1'b0;
         unl_q   <= 1'b0;
         busy_q  <= 1'b0;
         tmr_q   <= '0;
         txe_q   <= 1'b0;
         txd_q   <= '0;
         led_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         idx_q   <= idx_n;
         mis_q   <= mis_n;
         rep_q   <= rep_n;
         rlk_q   <= rlk_n;
         tog_q   <= tog_n;
         fail_q  <= fail_n;
         lock_q  <= lock_n;
         unl_q   <= unl_n;
         busy_q  <= busy_n;
         tmr_q   <= tmr_n;
         txe_q   <= txe_n;
         txd_q   <= txd_n;
         led_q   <= led_n;
      end
   end

   // Secret buffer: power-up pattern, written byte-wise in SET.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            secret_q[i] <= DW'(init_byte(i));
         end
      end else if (wr_en) begin
         secret_q[idx_q] <= rx_data;
      end
   end

   pulse_stretch #(
      .RST_CYCLES (RST_CYCLES)
   ) u_pulse (
      .clk       (clk),
      .rst_n     (rst_n),
      .trig      (esc),
      .tgt_rst_n (tgt_rst_n)
   );

   assign tx_en    = txe_q;
   assign tx_data  = txd_q;
   assign led      = led_q;
   assign locked   = lock_q;
   assign unlocked = unl_q;

endmodule

// File: tb/tb_uart_pwd_ctrl.sv
// Directed plus randomized bench for uart_pwd_ctrl with a
// transaction-level model of the secret, unlock and lockout rules.
module tb_uart_pwd_ctrl;

   localparam int DEPTH = 16;
   localparam int DW    = 8;
   localparam int MAXF  = 3;
   localparam int RSTC  = 32;
   localparam int TMO   = 300;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] rx_data = '0;
   logic          rx_valid = 1'b0;
   logic          tx_rdy = 1'b1;
   logic          tx_en;
   logic [DW-1:0] tx_data;
   logic          led;
   logic          tgt_rst_n;
   logic          locked;
   logic          unlocked;

   always #5 clk = ~clk;

   uart_pwd_ctrl #(
      .DEPTH       (DEPTH),
      .DW          (DW),
      .MAX_FAIL    (MAXF),
      .RST_CYCLES  (RSTC),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .tx_rdy    (tx_rdy),
      .tx_en     (tx_en),
      .tx_data   (tx_data),
      .led       (led),
      .tgt_rst_n (tgt_rst_n),
      .locked    (locked),
      .unlocked  (unlocked)
   );

   int vec  = 0;
   int miss = 0;

   logic [7:0] txq [$];
   int  n_txen = 0;
   int  proto_err = 0;
   int  hold = 0;
   bit  stall = 1'b0;
   logic prev_en = 1'b0;
   logic prev_rdy = 1'b1;

   int low_run = 0;
   int last_run = 0;

   logic [7:0] m_sec [DEPTH];
   bit m_unl;
   bit m_lock;
   int m_fail;

   // Transmitter: captures bytes, drops ready for a while.
   always @(negedge clk) begin
      if (tx_en) begin
         if (prev_en || !prev_rdy) proto_err++;
         txq.push_back(tx_data);
         n_txen++;
         hold = 2 + int'($urandom_range(0, 3));
      end else if (hold > 0) begin
         hold--;
      end
      prev_en = tx_en;
      tx_rdy = (hold == 0) && !stall;
      prev_rdy = tx_rdy;
   end

   // Length of the most recent completed low pulse.
   always @(negedge clk) begin
      if (!tgt_rst_n) begin
         low_run++;
      end else if (low_run != 0) begin
         last_run = low_run;
         low_run = 0;
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] o,
                      input logic [31:0] e);
      vec++;
      assert (o === e) else begin
         miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      rx_data = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      tick(gap);
   endtask

   task automatic expect_rx(input string tag, input logic [7:0] e);
      int t;
      t = 0;
      while (txq.size() == 0 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (txq.size() == 0) chk({tag, "_tmo"}, txq.size(), 1);
      else chk(tag, txq.pop_front(), e);
   endtask

   task automatic m_reset();
      for (int i = 0; i < DEPTH; i++) m_sec[i] = 8'h41 + 8'(i);
      m_unl = 0;
      m_lock = 0;
      m_fail = 0;
   endtask

   task automatic do_set(input logic [7:0] d [DEPTH]);
      send(8'h73, 1);
      for (int i = 0; i < DEPTH; i++)
         send(d[i], int'($urandom_range(0, 3)));
      m_sec = d;
      m_unl = 0;
      expect_rx("set_reply", 8'h4B);
      chk("set_unlocked", unlocked, m_unl);
   endtask

   task automatic do_verify(input logic [7:0] d [DEPTH]);
      bit mism;
      logic [7:0] e;
      mism = 0;
      for (int i = 0; i < DEPTH; i++)
         if (d[i] != m_sec[i]) mism = 1;
      send(8'h76, 1);
      for (int i = 0; i < DEPTH - 1; i++)
         send(d[i], int'($urandom_range(0, 3)));
      tick(4);
      chk("ver_no_early", txq.size(), 0);
      send(d[DEPTH-1], 0);
      if (!mism) begin
         m_unl = 1;
         m_fail = 0;
         e = 8'h59;
      end else begin
         m_unl = 0;
         if (m_fail < MAXF) m_fail++;
         if (m_fail == MAXF) m_lock = 1;
         e = 8'h4E;
      end
      expect_rx("ver_reply", e);
      chk("ver_unlocked", unlocked, m_unl);
      chk("ver_locked", locked, m_lock);
   endtask

   task automatic do_get();
      send(8'h67, 0);
      if (m_unl) begin
         for (int i = 0; i < DEPTH; i++)
            expect_rx("dump_byte", m_sec[i]);
      end else begin
         expect_rx("get_denied", 8'h4E);
      end
   endtask

   logic [7:0] d [DEPTH];
   int base;
   int t0;

   initial begin
      m_reset();
      tick(3);
      chk("rst_tx_en", tx_en, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_led", led, 0);
      chk("rst_tgt", tgt_rst_n, 1);
      chk("rst_locked", locked, 0);
      chk("rst_unlocked", unlocked, 0);
      rst_n = 1'b1;
      tick(3);
      chk("idle_led", led, 1);

      do_get();
      do_verify(m_sec);
      do_get();

      for (int i = 0; i < DEPTH; i++) d[i] = 8'(i);
      do_set(d);
      do_verify(d);
      d[DEPTH-1] = 8'hFF;
      do_verify(d);

      for (int it = 0; it < 5; it++) begin
         for (int i = 0; i < DEPTH; i++) d[i] = 8'($urandom);
         do_set(d);
         if (m_fail < MAXF - 1 && $urandom_range(0, 1) == 1) begin
            d[$urandom_range(0, DEPTH-1)] ^= 8'(1 + $urandom_range(0, 254));
            do_verify(d);
            d = m_sec;
         end
         do_verify(d);
         if ($urandom_range(0, 1) == 1) do_get();
      end

      send(8'h78, 0);
      expect_rx("echo_x", 8'h78);
      send(8'h74, 2);
      chk("led_toggled", led, 0);
      send(8'h74, 2);
      chk("led_restored", led, 1);

      send(8'h1B, 0);
      tick(1);
      chk("esc_low", tgt_rst_n, 0);
      tick(40);
      chk("esc_len", last_run, RSTC);
      send(8'h1B, 19);
      send(8'h1B, 0);
      tick(60);
      chk("esc_restart_len", last_run, 20 + RSTC);
      chk("esc_no_echo", txq.size(), 0);

      for (int i = 0; i < DEPTH; i++) d[i] = m_sec[i] ^ 8'h5A;
      while (!m_lock) do_verify(d);
      chk("lock_fail_cnt", m_fail, MAXF);
      send(8'h76, 0);
      expect_rx("locked_cmd", 8'h4C);
      for (int i = 0; i < DEPTH; i++) begin
         send(m_sec[i], 0);
         expect_rx("locked_pay", 8'h4C);
      end
      chk("still_locked", locked, 1);
      send(8'h1B, 0);
      tick(40);
      chk("locked_esc_len", last_run, RSTC);
      chk("locked_esc_quiet", txq.size(), 0);

      rst_n = 1'b0;
      tick(2);
      chk("rst_clears_lock", locked, 0);
      rst_n = 1'b1;
      m_reset();
      tick(2);

      send(8'h73, 1);
      for (int i = 0; i < 5; i++) begin
         m_sec[i] = 8'($urandom);
         send(m_sec[i], (i == 4) ? 0 : 1);
      end
      t0 = 0;
      while (txq.size() == 0 && t0 < TMO + 50) begin
         @(negedge clk);
         t0++;
      end
      chk("tmo_window", (t0 >= TMO - 2) && (t0 <= TMO + 10), 1);
      expect_rx("tmo_reply", 8'h54);
      chk("tmo_sec5", m_sec[5], 8'h46);
      do_verify(m_sec);

      stall = 1'b1;
      tick(2);
      base = n_txen;
      send(8'h67, 0);
      tick(100);
      chk("stall_no_txen", n_txen - base, 0);
      stall = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         expect_rx("stall_dump", m_sec[i]);
      tick(20);
      chk("dump_txen_cnt", n_txen - base, DEPTH);
      chk("tx_protocol", proto_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
